// File: rtl/cursor_ctrl.sv
// Purpose: four-button cursor controller (sync, debounce, auto-repeat, bounded px/py, frame-latched sx/sy).
// Latency: 2 sync + DEBOUNCE_CYC debounce cycles to the first step, 1 cycle step->px/py, sx/sy on frame_start.
// Backpressure: none; buttons are free-running levels and frame_start is a strobe.
// Build option: define CURSOR_WRAP_EN for wrap-around at the edges instead of saturation.
module cursor_ctrl #(
    parameter int COORD_W      = 12,
    parameter int H_MAX        = 639,
    parameter int V_MAX        = 479,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               frame_start,
    output logic [COORD_W-1:0] sx,
    output logic [COORD_W-1:0] sy,
    output logic               moving
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RP_W-1:0]    RD_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0]    RR_LAST = RP_W'(REPEAT_RATE - 1);
    localparam logic [COORD_W-1:0] H_TOP   = COORD_W'(H_MAX);
    localparam logic [COORD_W-1:0] V_TOP   = COORD_W'(V_MAX);
    localparam logic [COORD_W-1:0] H_MID   = COORD_W'(H_MAX / 2);
    localparam logic [COORD_W-1:0] V_MID   = COORD_W'(V_MAX / 2);
    localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    // Bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right.
    logic [3:0]         w_btn;
    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [3:0]         r_db;
    logic [DB_W-1:0]    r_dcnt [4];
    state_t             r_state [4];
    state_t             w_state_nxt [4];
    logic [RP_W-1:0]    r_rcnt [4];
    logic [RP_W-1:0]    w_rcnt_nxt [4];
    logic [3:0]         w_step;
    logic               w_up;
    logic               w_down;
    logic               w_left;
    logic               w_right;
    logic [COORD_W-1:0] r_px;
    logic [COORD_W-1:0] r_py;
    logic [COORD_W-1:0] w_px_nxt;
    logic [COORD_W-1:0] w_py_nxt;
    logic [COORD_W-1:0] r_sx;
    logic [COORD_W-1:0] r_sy;
    logic               r_moving;

    assign w_btn  = {btn_right, btn_left, btn_down, btn_up};
    assign sx     = r_sx;
    assign sy     = r_sy;
    assign moving = r_moving;

    // Synchronize raw buttons, then accept a level change only after DEBOUNCE_CYC stable cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            for (int i = 0; i < 4; i++) r_dcnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DB_LAST) begin
                    r_db[i]   <= ~r_db[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Auto-repeat state and interval counter per button.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= ST_IDLE;
                r_rcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_rcnt[i]  <= w_rcnt_nxt[i];
            end
        end
    end

    // Next state and step strobe: step on press, on leaving DELAY, and every REPEAT_RATE in REPEAT.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_state_nxt[i] = r_state[i];
            w_rcnt_nxt[i]  = r_rcnt[i];
            w_step[i]      = 1'b0;
            if (!r_db[i]) begin
                w_state_nxt[i] = ST_IDLE;
                w_rcnt_nxt[i]  = '0;
            end else begin
                case (r_state[i])
                    ST_IDLE: begin
                        w_state_nxt[i] = ST_DELAY;
                        w_rcnt_nxt[i]  = '0;
                        w_step[i]      = 1'b1;
                    end
                    ST_DELAY: begin
                        if (r_rcnt[i] == RD_LAST) begin
                            w_state_nxt[i] = ST_REPEAT;
                            w_rcnt_nxt[i]  = '0;
                            w_step[i]      = 1'b1;
                        end else begin
                            w_rcnt_nxt[i] = r_rcnt[i] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (r_rcnt[i] == RR_LAST) begin
                            w_rcnt_nxt[i] = '0;
                            w_step[i]     = 1'b1;
                        end else begin
                            w_rcnt_nxt[i] = r_rcnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = ST_IDLE;
                        w_rcnt_nxt[i]  = '0;
                    end
                endcase
            end
        end
    end

    // Opposing steps in the same cycle cancel.
    assign w_up    = w_step[0] & ~w_step[1];
    assign w_down  = w_step[1] & ~w_step[0];
    assign w_left  = w_step[2] & ~w_step[3];
    assign w_right = w_step[3] & ~w_step[2];

    // Next position: edge is tested before moving so the coordinate never leaves 0..MAX.
    always_comb begin
        w_px_nxt = r_px;
        w_py_nxt = r_py;
        if (w_left) begin
            if (r_px == '0) begin
`ifdef CURSOR_WRAP_EN
                w_px_nxt = H_TOP;
`else
                w_px_nxt = '0;
`endif
            end else begin
                w_px_nxt = r_px - ONE;
            end
        end else if (w_right) begin
            if (r_px >= H_TOP) begin
`ifdef CURSOR_WRAP_EN
                w_px_nxt = '0;
`else
                w_px_nxt = H_TOP;
`endif
            end else begin
                w_px_nxt = r_px + ONE;
            end
        end
        if (w_up) begin
            if (r_py == '0) begin
`ifdef CURSOR_WRAP_EN
                w_py_nxt = V_TOP;
`else
                w_py_nxt = '0;
`endif
            end else begin
                w_py_nxt = r_py - ONE;
            end
        end else if (w_down) begin
            if (r_py >= V_TOP) begin
`ifdef CURSOR_WRAP_EN
                w_py_nxt = '0;
`else
                w_py_nxt = V_TOP;
`endif
            end else begin
                w_py_nxt = r_py + ONE;
            end
        end
    end

    // Position registers; sx/sy only follow px/py at frame start so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_px     <= H_MID;
            r_py     <= V_MID;
            r_sx     <= H_MID;
            r_sy     <= V_MID;
            r_moving <= 1'b0;
        end else begin
            r_px     <= w_px_nxt;
            r_py     <= w_py_nxt;
            r_moving <= |r_db;
            if (frame_start) begin
                r_sx <= r_px;
                r_sy <= r_py;
            end
        end
    end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Purpose: self-checking bench for cursor_ctrl against a cycle-level behavioural model.
// Latency: model mirrors the observable timing only (sx, sy, moving checked every cycle).
// Backpressure: none.
module tb_cursor_ctrl;

    localparam int CW = 12;
    localparam int HM = 639;
    localparam int VM = 479;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_up;
    logic          btn_down;
    logic          btn_left;
    logic          btn_right;
    logic          frame_start;
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic          moving;

    always #5 clk = ~clk;

    cursor_ctrl #(
        .COORD_W      (CW),
        .H_MAX        (HM),
        .V_MAX        (VM),
        .DEBOUNCE_CYC (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .frame_start (frame_start),
        .sx          (sx),
        .sy          (sy),
        .moving      (moving)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buttons indexed 0 = up, 1 = down, 2 = left, 3 = right.
    // m_age is how many cycles the debounced level has been high (0 = first high cycle).
    int m_s1 [4];
    int m_s2 [4];
    int m_db [4];
    int m_run [4];
    int m_age [4];
    int m_px, m_py, m_sx, m_sy, m_mov;
    bit m_ok = 1'b0;

    logic [3:0] w_in;
    assign w_in = {btn_right, btn_left, btn_down, btn_up};

    function automatic int stepping(input int i);
        if (m_db[i] == 0) return 0;
        if (m_age[i] == 0 || m_age[i] == RD) return 1;
        if (m_age[i] > RD && ((m_age[i] - RD) % RR) == 0) return 1;
        return 0;
    endfunction

    function automatic int bound(input int v, input int top);
`ifdef CURSOR_WRAP_EN
        if (v < 0) return top;
        if (v > top) return 0;
`else
        if (v < 0) return 0;
        if (v > top) return top;
`endif
        return v;
    endfunction

    always @(posedge clk) begin : model
        int st [4];
        int ndb;
        if (rst) begin
            m_ok  = 1'b1;
            m_px  = HM / 2;
            m_py  = VM / 2;
            m_sx  = HM / 2;
            m_sy  = VM / 2;
            m_mov = 0;
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0; m_age[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) st[i] = stepping(i);
            if (frame_start) begin
                m_sx = m_px;
                m_sy = m_py;
            end
            m_px  = bound(m_px + st[3] - st[2], HM);
            m_py  = bound(m_py + st[1] - st[0], VM);
            m_mov = (m_db[0] | m_db[1] | m_db[2] | m_db[3]) != 0 ? 1 : 0;
            for (int i = 0; i < 4; i++) begin
                ndb = m_db[i];
                if (m_s2[i] == m_db[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i] + 1 == DB) begin
                    ndb      = 1 - m_db[i];
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
                m_age[i] = (ndb == 1 && m_db[i] == 1) ? m_age[i] + 1 : 0;
                m_db[i]  = ndb;
                m_s2[i]  = m_s1[i];
                m_s1[i]  = int'(w_in[i]);
            end
        end
    end

    // Every-cycle comparison of the visible outputs against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            check("sx_model", 32'(sx), m_sx);
            check("sy_model", 32'(sy), m_sy);
            check("moving_model", 32'(moving), m_mov);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic release_all();
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    endtask

    int cd [4];
    logic [3:0] rb;
    int c;

    initial begin
        rst = 1'b1; frame_start = 1'b0;
        release_all();
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset position reaches the outputs.
        pulse_fs();
        check("reset_sx", 32'(sx), 319);
        check("reset_sy", 32'(sy), 239);
        check("reset_moving", 32'(moving), 0);

        // Glitchy presses shorter than the debounce window are ignored.
        for (int k = 0; k < 4; k++) begin
            btn_right = 1'b1; tick(3);
            btn_right = 1'b0; tick(1);
        end
        tick(10);
        pulse_fs();
        check("glitch_sx", 32'(sx), 319);
        check("glitch_moving", 32'(moving), 0);

        // 50-cycle hold: steps at press, +20, +25..+45 -> 7 steps.
        btn_right = 1'b1;
        tick(50);
        btn_right = 1'b0;
        tick(6);
        check("moving_before_fall", 32'(moving), 1);
        tick(1);
        check("moving_after_fall", 32'(moving), 0);
        tick(4);
        pulse_fs();
        check("hold50_sx", 32'(sx), 326);

        // Opposing vertical buttons cancel.
        btn_up = 1'b1; btn_down = 1'b1;
        tick(100);
        check("updown_moving", 32'(moving), 1);
        release_all();
        tick(12);
        pulse_fs();
        check("updown_sy", 32'(sy), 239);

        // Diagonal: both axes move together.
        btn_left = 1'b1; btn_up = 1'b1;
        tick(50);
        release_all();
        tick(12);
        pulse_fs();
        check("diag_sx", 32'(sx), 319);
        check("diag_sy", 32'(sy), 232);

        // Left edge.
        btn_left = 1'b1;
        for (c = 0; c < 3000 && m_px != 0; c++) tick(1);
        check("reach_px0", m_px, 0);
`ifdef CURSOR_WRAP_EN
        for (c = 0; c < 30 && m_px == 0; c++) tick(1);
        pulse_fs();
        check("left_edge_sx", 32'(sx), 639);
`else
        tick(12);
        pulse_fs();
        check("left_edge_sx", 32'(sx), 0);
`endif
        release_all();
        tick(12);

        // Bottom edge.
        btn_down = 1'b1;
        for (c = 0; c < 3000 && m_py != VM; c++) tick(1);
        check("reach_pyMax", m_py, VM);
`ifdef CURSOR_WRAP_EN
        for (c = 0; c < 30 && m_py == VM; c++) tick(1);
        pulse_fs();
        check("bottom_edge_sy", 32'(sy), 0);
`else
        tick(12);
        pulse_fs();
        check("bottom_edge_sy", 32'(sy), 479);
`endif
        release_all();
        tick(12);

        // Reset during REPEAT with the button still held.
        btn_right = 1'b1;
        tick(40);
        rst = 1'b1;
        tick(2);
        check("rst_sx", 32'(sx), 319);
        check("rst_sy", 32'(sy), 239);
        check("rst_moving", 32'(moving), 0);
        rst = 1'b0;
        tick(6);
        check("post_rst_quiet", 32'(moving), 0);
        frame_start = 1'b1;
        tick(1);
        check("post_rst_sx_hold", 32'(sx), 319);
        check("post_rst_moving", 32'(moving), 1);
        tick(1);
        frame_start = 1'b0;
        check("post_rst_first_step", 32'(sx), 320);
        release_all();
        tick(12);

        // Randomized presses, frame pulses and occasional resets.
        for (int i = 0; i < 4; i++) cd[i] = $urandom_range(1, 40);
        rb = '0;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 4; i++) begin
                cd[i]--;
                if (cd[i] <= 0) begin
                    rb[i] = ~rb[i];
                    cd[i] = rb[i] ? $urandom_range(1, 60) : $urandom_range(1, 15);
                end
            end
            btn_up      = rb[0];
            btn_down    = rb[1];
            btn_left    = rb[2];
            btn_right   = rb[3];
            frame_start = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        release_all();
        rst = 1'b0;
        frame_start = 1'b0;
        tick(12);
        pulse_fs();
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
